// File: rtl/div_pkg.sv
// Shared types and constants for the divide sequencer.
// Holds the FSM state encoding and the divide-by-zero quotient.
`timescale 1ns/1ps
package div_pkg;

    // Sequencer states, in the order a division walks through them
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        WRITE  = 2'd3
    } div_state_t;

    // Cycles from the start pulse until the divider result is valid
    localparam int DIV_LATENCY_DEF = 32;

    // Quotient committed to LO when the divisor is zero
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's complement negation, wrapping mod 2^32.
// Turns signed operands into magnitudes and restores result signs.
`timescale 1ns/1ps
module div_sign_fix (
    input  logic [31:0] value,
    input  logic        negate,
    output logic [31:0] result
);

    // Negate when asked; -(2^31) stays 32'h80000000
    always_comb begin
        result = negate ? (32'd0 - value) : value;
    end

endmodule

// File: rtl/div_sequencer.sv
// Control stage in front of the multi-cycle unsigned divider.
// Optional feature macro: DIVSEQ_EARLY_OUT_EN (trivial quotients skip the divider).
`timescale 1ns/1ps
module div_sequencer
    import div_pkg::*;
#(
    parameter int DIV_LATENCY = DIV_LATENCY_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        rd_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               neg_r;
    logic               use_div;
    logic [31:0]        q_hold;
    logic [31:0]        r_hold;

    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        q_src;
    logic [31:0]        r_src;
    logic [31:0]        fix_q;
    logic [31:0]        fix_r;

    // Operand magnitudes for the unsigned divider
    div_sign_fix u_mag_a (
        .value  (req_a),
        .negate (req_signed & req_a[31]),
        .result (mag_a)
    );

    div_sign_fix u_mag_b (
        .value  (req_b),
        .negate (req_signed & req_b[31]),
        .result (mag_b)
    );

    // Result source: divider output or a value decided at accept time
    always_comb begin
        q_src = use_div ? div_q : q_hold;
        r_src = use_div ? div_r : r_hold;
    end

    // Restore result signs before commit
    div_sign_fix u_fix_q (
        .value  (q_src),
        .negate (neg_q),
        .result (fix_q)
    );

    div_sign_fix u_fix_r (
        .value  (r_src),
        .negate (neg_r),
        .result (fix_r)
    );

    // Hold the pipeline when it wants HI/LO or a new divide while busy
    always_comb begin
        stall = busy & (rd_req | req_valid);
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            use_div   <= 1'b0;
            q_hold    <= '0;
            r_hold    <= '0;
        end else begin
            done      <= 1'b0;
            div_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        div_a   <= mag_a;
                        div_b   <= mag_b;
                        busy    <= 1'b1;
                        neg_q   <= req_signed & (req_a[31] ^ req_b[31]);
                        neg_r   <= req_signed & req_a[31];
                        use_div <= 1'b1;
                        q_hold  <= '0;
                        r_hold  <= '0;
                        if (req_b == '0) begin
                            // Raw dividend goes to HI, never negated
                            use_div <= 1'b0;
                            q_hold  <= DIV_BY_ZERO_Q;
                            r_hold  <= req_a;
                            neg_q   <= 1'b0;
                            neg_r   <= 1'b0;
                            state   <= WRITE;
                        end
`ifdef DIVSEQ_EARLY_OUT_EN
                        else if (mag_a < mag_b) begin
                            use_div <= 1'b0;
                            q_hold  <= '0;
                            r_hold  <= mag_a;
                            state   <= WRITE;
                        end else if (mag_b == 32'd1) begin
                            use_div <= 1'b0;
                            q_hold  <= mag_a;
                            r_hold  <= '0;
                            state   <= WRITE;
                        end
`endif
                        else begin
                            div_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt   <= CNT_W'(DIV_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= WRITE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    lo    <= fix_q;
                    hi    <= fix_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
